// File: rtl/udt_pkg.sv
// Shared UDT receive-path definitions.
//   - UDT_CTRL_*   : 15-bit control packet type codes (header bits [62:48])
//   - udt_dst_e    : routing destination of a received packet
//   - udt_rx_state_e : receive demux packet-framing states
//   - udt_classify : header-beat classifier (runt / data / control type)
package udt_pkg;

  localparam logic [14:0] UDT_CTRL_HS        = 15'h0000;
  localparam logic [14:0] UDT_CTRL_KEEPALIVE = 15'h0001;
  localparam logic [14:0] UDT_CTRL_ACK       = 15'h0002;
  localparam logic [14:0] UDT_CTRL_NAK       = 15'h0003;
  localparam logic [14:0] UDT_CTRL_SHUTDOWN  = 15'h0005;
  localparam logic [14:0] UDT_CTRL_ACK2      = 15'h0006;

  typedef enum logic [2:0] {
    DST_HS,
    DST_CLOSE,
    DST_CTRL,
    DST_DATA,
    DST_DROP
  } udt_dst_e;

  typedef enum logic [1:0] {
    ST_HEAD,
    ST_FWD,
    ST_DROP
  } udt_rx_state_e;

  // hdr_hi is tdata[63:48] of the first beat. A first beat carrying tlast
  // cannot hold the 16-byte header, so it is discarded whatever its type.
  function automatic udt_dst_e udt_classify(input logic [15:0] hdr_hi,
                                            input logic        is_last,
                                            input logic        drop_data);
    udt_dst_e d;
    if (is_last) begin
      d = DST_DROP;
    end else if (!hdr_hi[15]) begin
      d = drop_data ? DST_DROP : DST_DATA;
    end else begin
      case (hdr_hi[14:0])
        UDT_CTRL_HS:        d = DST_HS;
        UDT_CTRL_SHUTDOWN:  d = DST_CLOSE;
        UDT_CTRL_KEEPALIVE,
        UDT_CTRL_ACK,
        UDT_CTRL_NAK,
        UDT_CTRL_ACK2:      d = DST_CTRL;
        default:            d = DST_DROP;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/udt_axis_out_reg.sv
// Single AXI-stream register slice (64b data, 8b keep, last) with valid/ready.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load              write in_* into the slice this cycle (caller guarantees can_load)
//   in_tdata/tkeep/tlast  beat to store
//   can_load          slice is empty or is being drained this cycle
//   m_tvalid/tdata/tkeep/tlast, m_tready  registered AXI-stream output
module udt_axis_out_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [63:0] in_tdata,
  input  logic [7:0]  in_tkeep,
  input  logic        in_tlast,
  output logic        can_load,
  output logic        m_tvalid,
  output logic [63:0] m_tdata,
  output logic [7:0]  m_tkeep,
  output logic        m_tlast,
  input  logic        m_tready
);

  assign can_load = !m_tvalid || m_tready;

  // Payload only changes on load, so it stays stable while valid waits for ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
    end else if (load) begin
      m_tvalid <= 1'b1;
      m_tdata  <= in_tdata;
      m_tkeep  <= in_tkeep;
      m_tlast  <= in_tlast;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/udt_rx_pkt_demux.sv
// UDT receive packet classifier/router. Decodes the header of each input
// AXI-stream frame and routes the whole frame to handshake_*, close_*,
// ctrl_* or data_*; malformed/unknown frames are sunk and counted.
// Ports:
//   core_clk, core_rst_n        clock, asynchronous active-low reset
//   s_*                         input packets (byte 0 in tdata[63:56])
//   handshake_* / close_* / ctrl_* / data_*   registered output streams
//   rsp_pulse                   1-cycle pulse per forwarded packet
//   rx_pkt_cnt / drop_cnt       wrap-around forwarded / dropped packet counts
module udt_rx_pkt_demux
  import udt_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter bit          DROP_DATA = 1'b0
) (
  input  logic             core_clk,
  input  logic             core_rst_n,
  input  logic [63:0]      s_tdata,
  input  logic [7:0]       s_tkeep,
  input  logic             s_tvalid,
  input  logic             s_tlast,
  output logic             s_tready,
  output logic [63:0]      handshake_tdata,
  output logic [7:0]       handshake_tkeep,
  output logic             handshake_tvalid,
  output logic             handshake_tlast,
  input  logic             handshake_tready,
  output logic [63:0]      close_tdata,
  output logic [7:0]       close_tkeep,
  output logic             close_tvalid,
  output logic             close_tlast,
  input  logic             close_tready,
  output logic [63:0]      ctrl_tdata,
  output logic [7:0]       ctrl_tkeep,
  output logic             ctrl_tvalid,
  output logic             ctrl_tlast,
  input  logic             ctrl_tready,
  output logic [63:0]      data_tdata,
  output logic [7:0]       data_tkeep,
  output logic             data_tvalid,
  output logic             data_tlast,
  input  logic             data_tready,
  output logic             rsp_pulse,
  output logic [CNT_W-1:0] rx_pkt_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  udt_rx_state_e state, next_state;
  udt_dst_e      dst_q, head_dst, cur_dst;
  logic          accept, first_acc;
  logic          hs_can, close_can, ctrl_can, data_can;
  logic          hs_load, close_load, ctrl_load, data_load;

  assign head_dst  = udt_classify(s_tdata[63:48], s_tlast, DROP_DATA);
  assign accept    = s_tvalid && s_tready;
  assign first_acc = accept && (state == ST_HEAD);

  always_comb begin
    next_state = state;
    cur_dst    = DST_DROP;
    s_tready   = 1'b0;

    case (state)
      ST_HEAD: cur_dst = head_dst;
      ST_FWD:  cur_dst = dst_q;
      default: cur_dst = DST_DROP;
    endcase

    // Ready looks only at the destination register, so unrelated
    // outputs stalling never blocks this packet.
    case (cur_dst)
      DST_HS:    s_tready = hs_can;
      DST_CLOSE: s_tready = close_can;
      DST_CTRL:  s_tready = ctrl_can;
      DST_DATA:  s_tready = data_can;
      default:   s_tready = 1'b1;
    endcase

    case (state)
      ST_HEAD: begin
        if (s_tvalid && s_tready && !s_tlast)
          next_state = (head_dst == DST_DROP) ? ST_DROP : ST_FWD;
      end
      ST_FWD, ST_DROP: begin
        if (s_tvalid && s_tready && s_tlast)
          next_state = ST_HEAD;
      end
      default: next_state = ST_HEAD;
    endcase
  end

  assign hs_load    = accept && (cur_dst == DST_HS);
  assign close_load = accept && (cur_dst == DST_CLOSE);
  assign ctrl_load  = accept && (cur_dst == DST_CTRL);
  assign data_load  = accept && (cur_dst == DST_DATA);

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state      <= ST_HEAD;
      dst_q      <= DST_DROP;
      rsp_pulse  <= 1'b0;
      rx_pkt_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      state     <= next_state;
      rsp_pulse <= 1'b0;
      if (first_acc) begin
        dst_q <= head_dst;
        if (head_dst == DST_DROP) begin
          drop_cnt <= drop_cnt + 1'b1;
        end else begin
          rx_pkt_cnt <= rx_pkt_cnt + 1'b1;
          rsp_pulse  <= 1'b1;
        end
      end
    end
  end

  udt_axis_out_reg u_hs_reg (
    .clk(core_clk), .rst_n(core_rst_n), .load(hs_load),
    .in_tdata(s_tdata), .in_tkeep(s_tkeep), .in_tlast(s_tlast), .can_load(hs_can),
    .m_tvalid(handshake_tvalid), .m_tdata(handshake_tdata), .m_tkeep(handshake_tkeep),
    .m_tlast(handshake_tlast), .m_tready(handshake_tready)
  );

  udt_axis_out_reg u_close_reg (
    .clk(core_clk), .rst_n(core_rst_n), .load(close_load),
    .in_tdata(s_tdata), .in_tkeep(s_tkeep), .in_tlast(s_tlast), .can_load(close_can),
    .m_tvalid(close_tvalid), .m_tdata(close_tdata), .m_tkeep(close_tkeep),
    .m_tlast(close_tlast), .m_tready(close_tready)
  );

  udt_axis_out_reg u_ctrl_reg (
    .clk(core_clk), .rst_n(core_rst_n), .load(ctrl_load),
    .in_tdata(s_tdata), .in_tkeep(s_tkeep), .in_tlast(s_tlast), .can_load(ctrl_can),
    .m_tvalid(ctrl_tvalid), .m_tdata(ctrl_tdata), .m_tkeep(ctrl_tkeep),
    .m_tlast(ctrl_tlast), .m_tready(ctrl_tready)
  );

  udt_axis_out_reg u_data_reg (
    .clk(core_clk), .rst_n(core_rst_n), .load(data_load),
    .in_tdata(s_tdata), .in_tkeep(s_tkeep), .in_tlast(s_tlast), .can_load(data_can),
    .m_tvalid(data_tvalid), .m_tdata(data_tdata), .m_tkeep(data_tkeep),
    .m_tlast(data_tlast), .m_tready(data_tready)
  );

endmodule

// File: tb/tb_udt_rx_pkt_demux.sv
// Self-checking bench for udt_rx_pkt_demux: directed scenarios plus a
// randomized packet stream, checked against a packet-level reference model.
module tb_udt_rx_pkt_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tkeep = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [63:0] o_tdata  [4];
  logic [7:0]  o_tkeep  [4];
  logic        o_tvalid [4];
  logic        o_tlast  [4];
  logic [3:0]  rdy = '1;
  logic        rsp_pulse;
  logic [31:0] rx_pkt_cnt, drop_cnt;

  // second instance with DROP_DATA=1, driven only by its own inputs
  logic [63:0] dd_s_tdata = '0;
  logic [7:0]  dd_s_tkeep = '0;
  logic        dd_s_tvalid = 1'b0;
  logic        dd_s_tlast = 1'b0;
  logic        dd_s_tready;
  logic [63:0] dd_tdata  [4];
  logic [7:0]  dd_tkeep  [4];
  logic        dd_tvalid [4];
  logic        dd_tlast  [4];
  logic [3:0]  dd_rdy = '1;
  logic        dd_rsp_pulse;
  logic [31:0] dd_rx_cnt, dd_drop_cnt;

  always #5 clk = ~clk;

  udt_rx_pkt_demux #(.CNT_W(32), .DROP_DATA(1'b0)) u_dut (
    .core_clk(clk), .core_rst_n(rst_n),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .handshake_tdata(o_tdata[0]), .handshake_tkeep(o_tkeep[0]), .handshake_tvalid(o_tvalid[0]),
    .handshake_tlast(o_tlast[0]), .handshake_tready(rdy[0]),
    .close_tdata(o_tdata[1]), .close_tkeep(o_tkeep[1]), .close_tvalid(o_tvalid[1]),
    .close_tlast(o_tlast[1]), .close_tready(rdy[1]),
    .ctrl_tdata(o_tdata[2]), .ctrl_tkeep(o_tkeep[2]), .ctrl_tvalid(o_tvalid[2]),
    .ctrl_tlast(o_tlast[2]), .ctrl_tready(rdy[2]),
    .data_tdata(o_tdata[3]), .data_tkeep(o_tkeep[3]), .data_tvalid(o_tvalid[3]),
    .data_tlast(o_tlast[3]), .data_tready(rdy[3]),
    .rsp_pulse(rsp_pulse), .rx_pkt_cnt(rx_pkt_cnt), .drop_cnt(drop_cnt)
  );

  udt_rx_pkt_demux #(.CNT_W(32), .DROP_DATA(1'b1)) u_dut_dd (
    .core_clk(clk), .core_rst_n(rst_n),
    .s_tdata(dd_s_tdata), .s_tkeep(dd_s_tkeep), .s_tvalid(dd_s_tvalid), .s_tlast(dd_s_tlast),
    .s_tready(dd_s_tready),
    .handshake_tdata(dd_tdata[0]), .handshake_tkeep(dd_tkeep[0]), .handshake_tvalid(dd_tvalid[0]),
    .handshake_tlast(dd_tlast[0]), .handshake_tready(dd_rdy[0]),
    .close_tdata(dd_tdata[1]), .close_tkeep(dd_tkeep[1]), .close_tvalid(dd_tvalid[1]),
    .close_tlast(dd_tlast[1]), .close_tready(dd_rdy[1]),
    .ctrl_tdata(dd_tdata[2]), .ctrl_tkeep(dd_tkeep[2]), .ctrl_tvalid(dd_tvalid[2]),
    .ctrl_tlast(dd_tlast[2]), .ctrl_tready(dd_rdy[2]),
    .data_tdata(dd_tdata[3]), .data_tkeep(dd_tkeep[3]), .data_tvalid(dd_tvalid[3]),
    .data_tlast(dd_tlast[3]), .data_tready(dd_rdy[3]),
    .rsp_pulse(dd_rsp_pulse), .rx_pkt_cnt(dd_rx_cnt), .drop_cnt(dd_drop_cnt)
  );

  // ---------------- reference model state ----------------
  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    int unsigned cyc;
  } beat_t;

  beat_t       expq [4][$];
  beat_t       mon_b;
  int unsigned exp_rx = 0, exp_drop = 0, rsp_seen = 0;
  int unsigned cyc = 0;
  int unsigned n_checks = 0, n_errors = 0;
  bit          lat_exact = 1'b0;
  bit          rnd_rdy = 1'b0;
  int          hold_cnt = 0;
  int unsigned stall_cnt = 0, data_in_hold = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Destination index 0..3 = hs/close/ctrl/data, 4 = discarded.
  function automatic int ref_dest(input logic [63:0] hdr, input int len, input bit drop_data);
    logic [14:0] t;
    if (len < 2) return 4;
    if (!hdr[63]) return drop_data ? 4 : 3;
    t = hdr[62:48];
    case (t)
      15'd0:                      return 0;
      15'd5:                      return 1;
      15'd1, 15'd2, 15'd3, 15'd6: return 2;
      default:                    return 4;
    endcase
  endfunction

  function automatic int unsigned pending();
    return expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size();
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (hold_cnt > 0) begin
      rdy = 4'b1110;
      hold_cnt--;
    end else if (rnd_rdy) begin
      rdy = 4'($urandom);
    end else begin
      rdy = '1;
    end
  end

  // Output monitor: every completed output handshake must match the model.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < 4; p++) begin
        if (o_tvalid[p] && rdy[p]) begin
          check($sformatf("beat_expected_p%0d", p), 64'(expq[p].size() != 0), 64'd1);
          if (expq[p].size() != 0) begin
            mon_b = expq[p].pop_front();
            check($sformatf("tdata_p%0d", p), o_tdata[p], mon_b.d);
            check($sformatf("tkeep_p%0d", p), 64'(o_tkeep[p]), 64'(mon_b.k));
            check($sformatf("tlast_p%0d", p), 64'(o_tlast[p]), 64'(mon_b.l));
            if (lat_exact) check($sformatf("latency_p%0d", p), 64'(cyc), 64'(mon_b.cyc));
          end
        end
      end
      if (rsp_pulse) rsp_seen++;
      if (hold_cnt > 0) begin
        if (s_tvalid && !s_tready) stall_cnt++;
        if (o_tvalid[3]) data_in_hold++;
      end
    end
  end

  // Presents n_send beats of a len-beat packet; called and returns at posedge+1.
  task automatic send_pkt(input logic [63:0] hdr, input int len, input int n_send,
                          input bit chk_rdy, input int max_gap);
    int dst, waited;
    logic [63:0] d;
    logic [7:0]  k;
    dst = ref_dest(hdr, len, 1'b0);
    for (int i = 0; i < n_send; i++) begin
      if (max_gap > 0) begin
        s_tvalid = 1'b0;
        repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
      end
      d = (i == 0) ? hdr : {$urandom, $urandom};
      k = (i == 0 && len > 1) ? 8'hFF : 8'($urandom_range(255, 1));
      s_tdata = d; s_tkeep = k; s_tlast = (i == len - 1); s_tvalid = 1'b1;
      waited = 0;
      forever begin
        @(negedge clk);
        if (chk_rdy && waited == 0) check("s_tready_high", 64'(s_tready), 64'd1);
        if (s_tready) break;
        waited++;
        if (waited > 500) begin
          check("accept_wait", 64'(s_tready), 64'd1);
          s_tvalid = 1'b0;
          return;
        end
        @(posedge clk); #1;
      end
      if (i == 0) begin
        if (dst == 4) exp_drop++; else exp_rx++;
      end
      if (dst != 4) expq[dst].push_back('{d, k, s_tlast, cyc + 1});
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int t;
    rnd_rdy = 1'b0;
    t = 0;
    while (pending() != 0 && t < 300) begin @(negedge clk); t++; end
    check("drain_empty", 64'(pending()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_rx_cnt"}, 64'(rx_pkt_cnt), 64'(exp_rx));
    check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
    check({tag, "_rsp"}, 64'(rsp_seen), 64'(exp_rx));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [63:0] hdr;
    logic [14:0] t;
    int          len, sel;
    logic [63:0] bd;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'({o_tvalid[0], o_tvalid[1], o_tvalid[2], o_tvalid[3]}), 64'd0);
    check("rst_tdata_hs", o_tdata[0], 64'd0);
    check("rst_rx_cnt", 64'(rx_pkt_cnt), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_rsp", 64'(rsp_pulse), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: handshake, 6 beats, exact 1-cycle latency
    lat_exact = 1'b1;
    send_pkt(64'h8000_0000_0000_0000, 6, 6, 1'b1, 0);
    drain();
    check_counts("hs");

    // 2: shutdown then ACK back to back
    send_pkt({1'b1, 15'd5, 48'h1234_5678_9ABC}, 2, 2, 1'b1, 0);
    send_pkt({1'b1, 15'd2, 48'h0BAD_F00D_0001}, 3, 3, 1'b1, 0);
    drain();
    check_counts("b2b");

    // 3: unknown type 4 then a 1-beat runt handshake, both sunk
    send_pkt({1'b1, 15'd4, 48'h0}, 4, 4, 1'b1, 0);
    send_pkt(64'h8000_0000_0000_0000, 1, 1, 1'b1, 0);
    drain();
    check_counts("drop");
    lat_exact = 1'b0;

    // 4: handshake output stalled mid-packet, data packet queued behind it
    stall_cnt = 0; data_in_hold = 0;
    fork
      begin
        send_pkt(64'h8000_0000_0000_0042, 8, 8, 1'b0, 0);
        send_pkt({1'b0, 63'h1357_9BDF_0246_8ACE}, 3, 3, 1'b0, 0);
      end
      begin
        repeat (3) @(negedge clk);
        hold_cnt = 10;
      end
    join
    drain();
    check("bp_stall_seen", 64'(stall_cnt > 0), 64'd1);
    check("bp_data_blocked", 64'(data_in_hold), 64'd0);
    check_counts("bp");

    // random traffic with random backpressure
    rnd_rdy = 1'b1;
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(9, 0);
      case (sel)
        8:       t = 15'h7FFF;
        default: t = 15'(sel);
      endcase
      hdr = {1'b1, t, 16'($urandom), $urandom};
      if (sel == 9) hdr[63] = 1'b0;
      len = $urandom_range(6, 1);
      send_pkt(hdr, len, len, 1'b0, 2);
      rnd_rdy = 1'b1;
    end
    drain();
    check_counts("rand");

    // 5: reset while beat 3 of a data packet is presented
    send_pkt({1'b0, 63'h0000_1111_2222_3333}, 6, 3, 1'b0, 0);
    s_tdata = 64'hDEAD_BEEF_0000_0003; s_tkeep = 8'hFF; s_tlast = 1'b0; s_tvalid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'({o_tvalid[0], o_tvalid[1], o_tvalid[2], o_tvalid[3]}), 64'd0);
    check("mid_rst_rx_cnt", 64'(rx_pkt_cnt), 64'd0);
    check("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
    s_tvalid = 1'b0;
    for (int p = 0; p < 4; p++) expq[p].delete();
    exp_rx = 0; exp_drop = 0; rsp_seen = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    lat_exact = 1'b1;
    send_pkt(64'h8000_0000_0000_0077, 4, 4, 1'b1, 0);
    drain();
    check_counts("post_rst");
    lat_exact = 1'b0;

    // 6: DROP_DATA=1 instance: data sunk, handshake forwarded
    for (int i = 0; i < 3; i++) begin
      dd_s_tdata = (i == 0) ? {1'b0, 63'h0ABC} : {$urandom, $urandom};
      dd_s_tkeep = 8'hFF; dd_s_tlast = (i == 2); dd_s_tvalid = 1'b1;
      @(negedge clk);
      check("dd_data_sink_ready", 64'(dd_s_tready), 64'd1);
      check("dd_data_no_valid", 64'({dd_tvalid[0], dd_tvalid[1], dd_tvalid[2], dd_tvalid[3]}), 64'd0);
      @(posedge clk); #1;
    end
    dd_s_tvalid = 1'b0;
    @(negedge clk);
    check("dd_data_no_valid_end", 64'({dd_tvalid[0], dd_tvalid[1], dd_tvalid[2], dd_tvalid[3]}), 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      bd = (i == 0) ? 64'h8000_0000_0000_0099 : {$urandom, $urandom};
      dd_s_tdata = bd; dd_s_tkeep = 8'hFF; dd_s_tlast = (i == 2); dd_s_tvalid = 1'b1;
      @(negedge clk);
      check("dd_hs_ready", 64'(dd_s_tready), 64'd1);
      @(posedge clk); #1;
      dd_s_tvalid = 1'b0;
      @(negedge clk);
      check("dd_hs_valid", 64'({dd_tvalid[0], dd_tvalid[1], dd_tvalid[2], dd_tvalid[3]}), 64'b1000);
      check("dd_hs_tdata", dd_tdata[0], bd);
      check("dd_hs_tlast", 64'(dd_tlast[0]), 64'(i == 2));
      @(posedge clk); #1;
    end
    check("dd_rx_cnt", 64'(dd_rx_cnt), 64'd1);
    check("dd_drop_cnt", 64'(dd_drop_cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
